// File: rtl/reset_sequencer.sv
// Staged reset release: hold all channels, then release them one by one in index order.
// Optional macro RESET_SEQ_LOCK_EN makes loss of PLL lock restart the sequence.
module reset_sequencer #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 24,
  parameter int HOLD_CYCLES     = 131071,
  parameter int STAGE_CYCLES    = 1024,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iReset_Switch,
  input  logic              iLock,
  output logic [NUM_CH-1:0] oReset_En,
  output logic              oDone
);

  localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGE_LOAD = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [NUM_CH-1:0] EN_ONE     = NUM_CH'(1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] w_en_nxt;

  logic             r_sw_meta;
  logic             r_sw_sync;
  logic             r_sw_db;
  logic [CNT_W-1:0] r_db_cnt;
  logic             w_lock;
  logic             w_restart;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_sw_meta <= 1'b0;
      r_sw_sync <= 1'b0;
      r_sw_db   <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sw_meta <= iReset_Switch;
      r_sw_sync <= r_sw_meta;
      // Counter only runs while the synchronised value disagrees with the accepted one.
      if (r_sw_sync != r_sw_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_sw_db  <= r_sw_sync;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + CNT_ONE;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

`ifdef RESET_SEQ_LOCK_EN
  logic r_lk_meta;
  logic r_lk_sync;

  // Lock synchroniser resets to "locked" so a steady lock does not stretch the first hold.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_lk_meta <= 1'b1;
      r_lk_sync <= 1'b1;
    end else begin
      r_lk_meta <= iLock;
      r_lk_sync <= r_lk_meta;
    end
  end

  assign w_lock = r_lk_sync;
`else
  logic w_unused_lock;
  assign w_unused_lock = iLock;
  assign w_lock        = 1'b1;
`endif

  assign w_restart = r_sw_db | ~w_lock;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state <= S_HOLD;
      r_cnt   <= HOLD_LOAD;
      r_en    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    oDone       = (r_state == S_DONE);
    if (w_restart) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = HOLD_LOAD;
      w_en_nxt    = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == '0) begin
            w_en_nxt    = EN_ONE;
            w_cnt_nxt   = STAGE_LOAD;
            w_state_nxt = (NUM_CH == 1) ? S_DONE : S_RELEASE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_RELEASE: begin
          if (r_cnt == '0) begin
            w_en_nxt  = (r_en << 1) | EN_ONE;
            w_cnt_nxt = STAGE_LOAD;
            if (w_en_nxt[NUM_CH-1]) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
          w_en_nxt    = '0;
        end
      endcase
    end
  end

  assign oReset_En = r_en;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random switch/lock/reset traffic,
// checked every cycle against a model based on "edges since the last restart".
module tb_reset_sequencer;

  localparam int NUM_CH = 4;
  localparam int HOLD   = 100;
  localparam int STAGE  = 10;
  localparam int DEB    = 4;

  logic              iClk = 1'b0;
  logic              iReset;
  logic              iReset_Switch;
  logic              iLock;
  logic [NUM_CH-1:0] oReset_En;
  logic              oDone;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_n   = 0;
  bit m_sw1 = 0;
  bit m_sw2 = 0;
  bit m_db  = 0;
  int m_run = 0;
  bit m_lk1 = 1;
  bit m_lk2 = 1;
  bit lock_idle;

  always #5 iClk = ~iClk;

  reset_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(24), .HOLD_CYCLES(HOLD),
    .STAGE_CYCLES(STAGE), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iReset_Switch(iReset_Switch),
    .iLock(iLock), .oReset_En(oReset_En), .oDone(oDone)
  );

  function automatic logic [NUM_CH-1:0] exp_en(input int n);
    int k;
    if (n < HOLD) return '0;
    k = (n - HOLD) / STAGE + 1;
    if (k > NUM_CH) k = NUM_CH;
    return NUM_CH'((1 << k) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit restart;
    bit lk;
    @(posedge iClk);
`ifdef RESET_SEQ_LOCK_EN
    lk = m_lk2;
`else
    lk = 1'b1;
`endif
    restart = m_db | ~lk;
    if (iReset) begin
      m_n = 0; m_sw1 = 0; m_sw2 = 0; m_db = 0; m_run = 0; m_lk1 = 1; m_lk2 = 1;
    end else begin
      if (restart) m_n = 0;
      else if (m_n < 100000) m_n++;
      if (m_sw2 != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db  = m_sw2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_sw2 = m_sw1; m_sw1 = iReset_Switch;
      m_lk2 = m_lk1; m_lk1 = iLock;
    end
    #1;
    chk("model_en", oReset_En, exp_en(m_n));
    chk("model_done", oDone, (exp_en(m_n) == {NUM_CH{1'b1}}));
  endtask

  initial begin
    int rise[NUM_CH];
    int done_e;
    int k;
    bit found;
    logic [NUM_CH-1:0] prev;
    int sw_left;
    int lk_left;

`ifdef RESET_SEQ_LOCK_EN
    lock_idle = 1'b1;
`else
    lock_idle = 1'b0;
`endif
    iReset = 1'b1; iReset_Switch = 1'b0; iLock = lock_idle;

    // Reset state and release timing
    repeat (3) tick();
    chk("reset_en", oReset_En, 0);
    chk("reset_done", oDone, 0);
    iReset = 1'b0;
    for (int b = 0; b < NUM_CH; b++) rise[b] = -1;
    done_e = -1;
    prev = '0;
    for (int e = 1; e <= 140; e++) begin
      tick();
      for (int b = 0; b < NUM_CH; b++)
        if (rise[b] < 0 && oReset_En[b]) rise[b] = e;
      if (done_e < 0 && oDone) done_e = e;
      chk("monotonic", ((oReset_En & prev) == prev), 1);
      prev = oReset_En;
    end
    for (int b = 0; b < NUM_CH; b++) chk("rise_edge", rise[b], HOLD + STAGE * b);
    chk("done_edge", done_e, HOLD + STAGE * (NUM_CH - 1));

    // Switch pulses in DONE: short one ignored, long one restarts
    iReset_Switch = 1'b1;
    repeat (3) tick();
    iReset_Switch = 1'b0;
    repeat (10) tick();
    chk("short_pulse_en", oReset_En, 4'hF);
    chk("short_pulse_done", oDone, 1);
    iReset_Switch = 1'b1;
    k = -1; found = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!found && oReset_En == 0 && !oDone) begin found = 1; k = i; end
    end
    chk("long_pulse_clear_edge", k, 7);
    iReset_Switch = 1'b0;
    repeat (150) tick();
    chk("switch_restart_done", oDone, 1);

`ifdef RESET_SEQ_LOCK_EN
    // Lock loss just after two channels are out
    iReset = 1'b1; tick(); iReset = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (oReset_En == 4'h3) found = 1;
    end
    chk("reach_0x3", found, 1);
    iLock = 1'b0;
    k = -1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (k < 0 && oReset_En == 0) k = i;
    end
    chk("lock_clear_within3", (k >= 1 && k <= 3), 1);
    chk("lock_low_en", oReset_En, 0);
    iLock = 1'b1;
    repeat (150) tick();
    chk("lock_restart_done", oDone, 1);
`else
    // Lock is ignored in this build
    for (int i = 0; i < 200; i++) begin
      iLock = 1'($urandom_range(0, 1));
      tick();
    end
    iLock = lock_idle;
    chk("lock_ignored_done", oDone, 1);
`endif

    // One-cycle reset pulse midway through the hold
    iReset = 1'b1; tick(); iReset = 1'b0;
    repeat (50) tick();
    iReset = 1'b1; tick();
    chk("midhold_reset_en", oReset_En, 0);
    iReset = 1'b0;
    k = -1;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (k < 0 && oReset_En[0]) k = i;
    end
    chk("midhold_reset_rise", k, HOLD);

    // Switch held across reset release
    iReset = 1'b1; iReset_Switch = 1'b1;
    repeat (10) tick();
    iReset = 1'b0;
    repeat (300) tick();
    chk("switch_held_en", oReset_En, 0);
    iReset_Switch = 1'b0;
    repeat (150) tick();
    chk("switch_release_done", oDone, 1);

    // Random traffic
    sw_left = 0; lk_left = 0;
    for (int c = 0; c < 6000; c++) begin
      iReset = ($urandom_range(0, 1499) == 0);
      if (sw_left > 0) sw_left--;
      else if ($urandom_range(0, 399) == 0) sw_left = $urandom_range(1, 9);
      iReset_Switch = (sw_left > 0);
`ifdef RESET_SEQ_LOCK_EN
      if (lk_left > 0) lk_left--;
      else if ($urandom_range(0, 499) == 0) lk_left = $urandom_range(1, 6);
      iLock = ~(lk_left > 0);
`else
      iLock = 1'($urandom_range(0, 1));
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
